// File: rtl/req_enc_pkg.sv
// Shared types and helpers for the request encoder: default width, clog2,
// and a lowest-set-bit search used by the priority encoder.
package req_enc_pkg;

    localparam int N_DEF = 4;
    localparam int MAX_N = 32;
    localparam int MAX_W = 5;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } slot_state_t;

    typedef struct packed {
        logic             found;
        logic [MAX_W-1:0] index;
    } lsb_res_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Scans downward so the last hit written is the lowest set bit.
    function automatic lsb_res_t lowest_set_index(input logic [MAX_N-1:0] vec);
        lsb_res_t res;
        res = '0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res.found = 1'b1;
                res.index = i[MAX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Combinational LSB-first priority encoder: N-bit vector to W-bit index plus found flag.
// Zero latency, no flow control.
module prio_enc_lsb
    import req_enc_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_idx,
    output logic         o_found
);

    logic [MAX_N-1:0] w_ext;
    lsb_res_t         w_res;

    always_comb begin
        w_ext          = '0;
        w_ext[N-1:0]   = i_vec;
        w_res          = lowest_set_index(w_ext);
    end

    assign o_idx   = w_res.index[W-1:0];
    assign o_found = w_res.found;

endmodule

// File: rtl/req_encoder_seq.sv
// Latches requests into a sticky pending vector and streams their indices lowest first;
// req to valid in two edges, one index per cycle; stalls hold idx while pending accumulates.
module req_encoder_seq
    import req_enc_pkg::*;
#(
    parameter int N = N_DEF,
    localparam int W = clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] pending,
    output logic         drop
);

    slot_state_t  r_state;
    slot_state_t  w_state_nxt;
    logic [W-1:0] r_idx;
    logic [N-1:0] r_pending;
    logic         r_drop;

    logic [W-1:0] w_sel;
    logic         w_found;
    logic         w_slot_free;
    logic         w_load;
    logic [N-1:0] w_load_mask;
    logic [N-1:0] w_pending_nxt;
    logic         w_drop_nxt;

    // Selection looks only at registered pending; req never reaches idx directly.
    prio_enc_lsb #(.N(N), .W(W)) u_prio (
        .i_vec   (r_pending),
        .o_idx   (w_sel),
        .o_found (w_found)
    );

    assign w_slot_free = (r_state == ST_EMPTY) || ready;
    assign w_load      = w_slot_free && w_found;

    always_comb begin
        w_load_mask = '0;
        if (w_load) w_load_mask[w_sel] = 1'b1;
    end

    // A req on the bit being loaded re-posts it; only merges into a still-pending bit drop.
    assign w_pending_nxt = (r_pending & ~w_load_mask) | req;
    assign w_drop_nxt    = |(req & r_pending & ~w_load_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_load) w_state_nxt = ST_HOLD;
            ST_HOLD:  if (ready)  w_state_nxt = w_load ? ST_HOLD : ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        valid = (r_state == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_pending <= '0;
            r_drop    <= 1'b0;
        end else begin
            if (w_load) r_idx <= w_sel;
            r_pending <= w_pending_nxt;
            r_drop    <= w_drop_nxt;
        end
    end

    assign idx     = r_idx;
    assign pending = r_pending;
    assign drop    = r_drop;

endmodule

// File: tb/tb_req_encoder_seq.sv
// Directed bench for req_encoder_seq (N=4): reset, ordering, stall, merge/drop, re-post, mid-op reset.
module tb_req_encoder_seq;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] idx;
    logic       valid;
    logic       ready;
    logic [3:0] pending;
    logic       drop;

    int checks;
    int errors;

    req_encoder_seq #(.N(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .idx     (idx),
        .valid   (valid),
        .ready   (ready),
        .pending (pending),
        .drop    (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [1:0] i,
                              input logic [3:0] p, input logic d);
        check({tag, ".valid"},   32'(valid),   32'(v));
        check({tag, ".idx"},     32'(idx),     32'(i));
        check({tag, ".pending"}, 32'(pending), 32'(p));
        check({tag, ".drop"},    32'(drop),    32'(d));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req    = 4'b1111;
        ready  = 1'b1;

        // Reset with all requests high
        tick();
        tick();
        expect_out("rst", 1'b0, 2'd0, 4'b0000, 1'b0);
        rst = 1'b0;
        req = 4'b0000;
        tick();
        expect_out("rst_rel", 1'b0, 2'd0, 4'b0000, 1'b0);

        // Single event on bit 2
        req = 4'b0100;
        tick();
        req = 4'b0000;
        expect_out("single_p", 1'b0, 2'd0, 4'b0100, 1'b0);
        tick();
        expect_out("single_v", 1'b1, 2'd2, 4'b0000, 1'b0);
        tick();
        expect_out("single_e", 1'b0, 2'd2, 4'b0000, 1'b0);

        // Ordering 0,1,3
        req = 4'b1011;
        tick();
        req = 4'b0000;
        expect_out("ord_p", 1'b0, 2'd2, 4'b1011, 1'b0);
        tick();
        expect_out("ord0", 1'b1, 2'd0, 4'b1010, 1'b0);
        tick();
        expect_out("ord1", 1'b1, 2'd1, 4'b1000, 1'b0);
        tick();
        expect_out("ord3", 1'b1, 2'd3, 4'b0000, 1'b0);
        tick();
        expect_out("ord_e", 1'b0, 2'd3, 4'b0000, 1'b0);

        // Stall: idx 0 held while bit 1 waits
        ready = 1'b0;
        req   = 4'b0011;
        tick();
        req = 4'b0000;
        expect_out("stl_p", 1'b0, 2'd3, 4'b0011, 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick();
            expect_out($sformatf("stl%0d", c), 1'b1, 2'd0, 4'b0010, 1'b0);
        end
        ready = 1'b1;
        tick();
        expect_out("stl_a0", 1'b1, 2'd1, 4'b0000, 1'b0);
        tick();
        expect_out("stl_a1", 1'b0, 2'd1, 4'b0000, 1'b0);

        // Merge into pending bit 3 while stalled on idx 0
        ready = 1'b0;
        req   = 4'b1001;
        tick();
        req = 4'b0000;
        tick();
        expect_out("mrg_h", 1'b1, 2'd0, 4'b1000, 1'b0);
        req = 4'b1000;
        tick();
        req = 4'b0000;
        expect_out("mrg_d", 1'b1, 2'd0, 4'b1000, 1'b1);
        tick();
        expect_out("mrg_d0", 1'b1, 2'd0, 4'b1000, 1'b0);
        // Re-posting the held bit is a fresh event, not a merge
        req = 4'b0001;
        tick();
        req = 4'b0000;
        expect_out("repost", 1'b1, 2'd0, 4'b1001, 1'b0);
        ready = 1'b1;
        tick();
        expect_out("mrg_x0", 1'b1, 2'd0, 4'b1000, 1'b0);
        tick();
        expect_out("mrg_x3", 1'b1, 2'd3, 4'b0000, 1'b0);
        tick();
        expect_out("mrg_e", 1'b0, 2'd3, 4'b0000, 1'b0);
        tick();
        check("mrg_once", 32'(valid), 32'd0);

        // Held req on the bit being loaded keeps it pending, no drop
        req = 4'b0001;
        tick();
        expect_out("hold1", 1'b0, 2'd3, 4'b0001, 1'b0);
        tick();
        expect_out("hold2", 1'b1, 2'd0, 4'b0001, 1'b0);
        tick();
        req = 4'b0000;
        expect_out("hold3", 1'b1, 2'd0, 4'b0001, 1'b0);
        tick();
        expect_out("hold4", 1'b1, 2'd0, 4'b0000, 1'b0);
        tick();
        expect_out("hold5", 1'b0, 2'd0, 4'b0000, 1'b0);

        // Reset mid-operation
        ready = 1'b0;
        req   = 4'b1110;
        tick();
        req = 4'b0000;
        tick();
        expect_out("mid_h", 1'b1, 2'd1, 4'b1100, 1'b0);
        req = 4'b0010;
        tick();
        req = 4'b0000;
        expect_out("mid_p", 1'b1, 2'd1, 4'b1110, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("mid_rst", 1'b0, 2'd0, 4'b0000, 1'b0);
        ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            expect_out($sformatf("mid_q%0d", c), 1'b0, 2'd0, 4'b0000, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_encoder_seq.md
Name: req_encoder_seq

Overview:
- Sequential counterpart of the 2x4 decoder: converts request lines into a stream of binary indices.
- Latches N request lines into a sticky pending vector.
- Emits the encoded index of one pending request at a time over a valid/ready handshake, lowest index first (bit 0 maps to index 0, which the decoder decodes back to output a).
- Sits between event sources and any consumer that takes a binary code, for example the existing decoder.

Parameters:
- N, default 4: number of request lines; must be at least 2.
- W, default 2: index width, equal to clog2(N); derived, not overridden independently.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request lines; sampled every edge; a 1 on bit k posts event k.
- idx  output  W  encoded index of the presented event; registered.
- valid  output  1  idx holds an event; registered.
- ready  input  1  consumer accepts idx when valid and ready are both high at an edge.
- pending  output  N  registered sticky vector of posted but not-yet-presented events.
- drop  output  1  registered one-cycle pulse: a posted event merged with an identical one already pending.

Behaviour:
- Reset (rst=1 at an edge, any time, including mid-transfer): pending=0, valid=0, idx=0, drop=0. Requests on that edge are ignored.
- Output slot is a 2-state machine:
  - EMPTY (valid=0) -> HOLD when the load condition is true.
  - HOLD (valid=1) -> EMPTY on accept with no load.
  - HOLD -> HOLD when accept and load occur together (back-to-back transfer).
- slot_free = !valid or (valid and ready).
- Load: if slot_free and pending != 0:
  - idx <= index of the lowest set bit of pending; valid <= 1.
  - That bit is cleared from pending on the same edge.
- If slot_free and pending == 0: valid <= 0; idx holds its last value.
- Pending update: pending <= (pending with the loaded bit cleared) OR req. A req on the loaded bit in the same cycle keeps that bit set, so the new event is retained.
- Selection uses the registered pending only; req is never bypassed to the output.
- Latency: req[k] high at edge t -> pending[k]=1 after t -> earliest valid=1 with idx=k after edge t+1.
- Throughput: one index per cycle while ready stays high.
- Stall: while valid=1 and ready=0, idx and valid hold stable and pending keeps accumulating.
- drop <= 1 for one cycle when, for some k, req[k]=1, pending[k]=1 and bit k is not loaded on that edge. Otherwise drop <= 0.
- A req bit held high for several cycles posts one event per edge. Repeated posts merge and pulse drop.
- The request currently held in idx is no longer pending. A new req on the same bit re-posts it with no drop.
- Priority is fixed, lowest index first. A continuously re-posted low bit may starve higher bits; this is accepted and documented.

Decomposition:
- Shared package req_enc_pkg:
  - Default N.
  - Function clog2.
  - Function lowest_set_index(vec), returning an index and a found flag.
- One combinational sub-module, prio_enc_lsb (N-wide vector -> W-bit index plus any flag). It is reused by the top level for the load decision.
- The top level holds the pending, output-slot and drop registers only.

Test Plan (N=4):
- Reset: hold rst=1 with req=4'b1111 for 2 cycles -> pending=0, valid=0, idx=0, drop=0. After release, pending is 0 until the next req.
- Single event: req=4'b0100 for one cycle, ready=1 -> one cycle later pending=4'b0100; next cycle valid=1, idx=2, pending=0; following cycle valid=0.
- Multi-event ordering: req=4'b1011 for one cycle, ready=1 -> idx sequence 0,1,3 on three consecutive cycles with valid=1, then valid=0.
- Stall: req=4'b0011, ready=0 -> idx=0 holds stable with valid=1 for 5 cycles and pending=4'b0010. Raise ready -> idx 0 then 1 accepted on consecutive edges.
- Merge/drop: with pending[3]=1 and output stalled on idx=0, pulse req=4'b1000 -> drop=1 for exactly one cycle, pending stays 4'b1000, and only one idx=3 transfer follows.
- Reset mid-operation: pending=4'b1110 and valid=1, idx=1 stalled; assert rst for one cycle -> valid=0, pending=0, and no further transfers.
